// File: rtl/tensor_buf_responder_pkg.sv
// Encodings shared between the DMA controller and the tensor-side responder.
package tensor_pkg;

  typedef enum logic [1:0] {
    SET_A = 2'd0,
    SET_B = 2'd1,
    SET_X = 2'd2,
    SET_W = 2'd3
  } set_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/tensor_buf_responder_sync_fifo.sv
// Circular synchronous FIFO with registered read data and a one-cycle valid pulse.
module sync_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATAWIDTH-1:0]   wdata,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic                   rvalid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees a slot in the same cycle, so push on full succeeds alongside it.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr  <= rptr + AW'(1);
        rdata <= mem[rptr];
      end
      rvalid <= pop_ok;
      count  <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/tensor_buf_responder.sv
// Tensor-side DMA endpoint: loads operand buffers A/B/W and drains X results
// from a FIFO to the memory bus.
module tensor_buf_responder
  import tensor_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int BUF_DEPTH  = 64,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tensor_wen,
  input  logic                         tensor_ren,
  input  logic [1:0]                   set,
  input  logic [DATAWIDTH-1:0]         depth_in,
  input  logic [DATAWIDTH-1:0]         width_in,
  input  logic [DATAWIDTH-1:0]         data_in,
  output logic [DATAWIDTH-1:0]         data_out,
  output logic                         data_out_valid,
  input  logic [1:0]                   rd_set,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
  output logic [DATAWIDTH-1:0]         rd_data,
  input  logic                         x_push,
  input  logic [DATAWIDTH-1:0]         x_data,
  output logic [3:0]                   loaded,
  output logic [$clog2(FIFO_DEPTH):0]  x_count,
  output logic [2:0]                   err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

  logic [DATAWIDTH-1:0] mem_a [BUF_DEPTH];
  logic [DATAWIDTH-1:0] mem_b [BUF_DEPTH];
  logic [DATAWIDTH-1:0] mem_w [BUF_DEPTH];

  state_e        state;
  set_e          cur_set;
  set_e          in_set;
  logic [PW-1:0] wptr;
  logic [PW-1:0] expected;
  logic [PW-1:0] burst_len;

  logic          buf_we;
  set_e          buf_sel;
  logic [AW-1:0] buf_waddr;
  logic          pop_req;
  logic          pop_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept_wen;

  assign in_set     = set_e'(set);
  // Truncation to PW bits equals (depth*width) mod 2^PW.
  assign burst_len  = PW'(depth_in) * PW'(width_in);
  assign accept_wen = (state == ST_IDLE || state == ST_DRAIN) && tensor_wen;
  assign pop_ok     = pop_req && !fifo_empty;

  always_comb begin
    buf_we    = 1'b0;
    buf_sel   = SET_A;
    buf_waddr = '0;
    pop_req   = 1'b0;
    if (!rst) begin
      if (accept_wen && in_set != SET_X) begin
        buf_we  = 1'b1;
        buf_sel = in_set;
      end else if (state == ST_LOAD && tensor_wen && wptr < PW'(BUF_DEPTH)) begin
        buf_we    = 1'b1;
        buf_sel   = cur_set;
        buf_waddr = wptr[AW-1:0];
      end
      if (!tensor_wen && tensor_ren) begin
        pop_req = (state == ST_DRAIN) || (state == ST_IDLE && in_set == SET_X);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      case (buf_sel)
        SET_A:   mem_a[buf_waddr] <= data_in;
        SET_B:   mem_b[buf_waddr] <= data_in;
        SET_W:   mem_w[buf_waddr] <= data_in;
        default: ;
      endcase
    end
  end

  // Write-first: a read hitting the word being written returns the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (buf_we && buf_sel == set_e'(rd_set) && buf_waddr == rd_addr) begin
      rd_data <= data_in;
    end else begin
      case (set_e'(rd_set))
        SET_A:   rd_data <= mem_a[rd_addr];
        SET_B:   rd_data <= mem_b[rd_addr];
        SET_W:   rd_data <= mem_w[rd_addr];
        default: rd_data <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_set  <= SET_A;
      wptr     <= '0;
      expected <= '0;
      loaded   <= '0;
      err      <= '0;
    end else begin
      if (tensor_wen && tensor_ren) begin
        err[2] <= 1'b1;
      end
      if ((x_push && fifo_full && !pop_ok) || (pop_req && fifo_empty)) begin
        err[1] <= 1'b1;
      end
      case (state)
        ST_IDLE, ST_DRAIN: begin
          if (tensor_wen) begin
            if (in_set == SET_X) begin
              err[2] <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              state          <= ST_LOAD;
              cur_set        <= in_set;
              expected       <= burst_len;
              wptr           <= PW'(1);
              loaded[in_set] <= 1'b0;
            end
          end else if (state == ST_IDLE) begin
            if (tensor_ren && in_set == SET_X) begin
              state <= ST_DRAIN;
            end
          end else if (!tensor_ren) begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (tensor_wen) begin
            if (wptr >= PW'(BUF_DEPTH)) begin
              err[0] <= 1'b1;
            end
            if (wptr != '1) begin
              wptr <= wptr + PW'(1);
            end
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (wptr == expected) begin
            loaded[cur_set] <= 1'b1;
          end else begin
            err[0] <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_x_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (x_push),
    .pop    (pop_req),
    .wdata  (x_data),
    .rdata  (data_out),
    .rvalid (data_out_valid),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (x_count)
  );

endmodule

// File: tb/tb_tensor_buf_responder.sv
// Self-checking bench for tensor_buf_responder: directed scenarios plus
// randomized loads and FIFO traffic against a queue/array reference model.
module tb_tensor_buf_responder;

  localparam int DW = 8;
  localparam int BD = 64;
  localparam int FD = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          tensor_wen;
  logic          tensor_ren;
  logic [1:0]    set;
  logic [DW-1:0] depth_in;
  logic [DW-1:0] width_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic [1:0]    rd_set;
  logic [5:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          x_push;
  logic [DW-1:0] x_data;
  logic [3:0]    loaded;
  logic [6:0]    x_count;
  logic [2:0]    err;

  int errors = 0;
  int checks = 0;

  // Reference model of the operand buffers.
  logic [7:0] m_a [BD];
  logic [7:0] m_b [BD];
  logic [7:0] m_w [BD];

  tensor_buf_responder #(
    .DATAWIDTH  (DW),
    .BUF_DEPTH  (BD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tensor_wen     (tensor_wen),
    .tensor_ren     (tensor_ren),
    .set            (set),
    .depth_in       (depth_in),
    .width_in       (width_in),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .rd_set         (rd_set),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .x_push         (x_push),
    .x_data         (x_data),
    .loaded         (loaded),
    .x_count        (x_count),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tensor_wen = 1'b0;
    tensor_ren = 1'b0;
    set        = 2'd0;
    depth_in   = '0;
    width_in   = '0;
    data_in    = '0;
    rd_set     = 2'd2;
    rd_addr    = '0;
    x_push     = 1'b0;
    x_data     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] model_rd(input logic [1:0] s, input int a);
    case (s)
      2'd0:    return m_a[a];
      2'd1:    return m_b[a];
      2'd3:    return m_w[a];
      default: return 8'h00;
    endcase
  endfunction

  // Drives an n-word write burst; base<0 means random data. Optionally reads
  // back the word being written at index probe_idx in the same cycle.
  task automatic do_load(input logic [1:0] s, input logic [7:0] d, input logic [7:0] w,
                         input int n, input int base, input int probe_idx,
                         output logic [7:0] probe);
    probe = '0;
    for (int i = 0; i < n; i++) begin
      tensor_wen = 1'b1;
      set        = s;
      depth_in   = d;
      width_in   = w;
      data_in    = (base >= 0) ? 8'(base + i) : 8'($urandom);
      if (i < BD) begin
        case (s)
          2'd0:    m_a[i] = data_in;
          2'd1:    m_b[i] = data_in;
          2'd3:    m_w[i] = data_in;
          default: ;
        endcase
      end
      if (i == probe_idx) begin
        rd_set  = s;
        rd_addr = 6'(i);
      end else begin
        rd_set = 2'd2;
      end
      tick();
      if (i == probe_idx) probe = rd_data;
    end
    tensor_wen = 1'b0;
    rd_set     = 2'd2;
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    checks++; if (loaded !== 4'h0) begin errors++; $display("FAIL reset_loaded: got %h want 0", loaded); end
    checks++; if (x_count !== 7'd0) begin errors++; $display("FAIL reset_x_count: got %0d want 0", x_count); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b want 000", err); end
    rst = 1'b0;
  endtask

  task automatic test_load_a();
    logic [7:0] probe;
    do_reset();
    do_load(2'd0, 8'd2, 8'd3, 6, 8'h10, 2, probe);
    checks++; if (probe !== 8'h12) begin errors++; $display("FAIL write_first: got %h want 12", probe); end
    checks++; if (loaded[0] !== 1'b1) begin errors++; $display("FAIL load_a_loaded: got %b want 1", loaded[0]); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL load_a_err: got %b want 000", err); end
    rd_set  = 2'd0;
    rd_addr = 6'd4;
    tick();
    checks++; if (rd_data !== 8'h14) begin errors++; $display("FAIL load_a_rd: got %h want 14", rd_data); end
    rd_set = 2'd2;
    tick();
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rd_set_x: got %h want 00", rd_data); end
  endtask

  task automatic test_short_burst();
    logic [7:0] probe;
    do_reset();
    do_load(2'd3, 8'd2, 8'd2, 3, 8'h40, -1, probe);
    checks++; if (loaded[3] !== 1'b0) begin errors++; $display("FAIL short_loaded: got %b want 0", loaded[3]); end
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL short_err0: got %b want 1", err[0]); end
  endtask

  task automatic test_x_drain();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      x_push = 1'b1;
      x_data = 8'(8'hA1 + i);
      exp_q.push_back(x_data);
      tick();
    end
    x_push = 1'b0;
    checks++; if (x_count !== 7'd3) begin errors++; $display("FAIL drain_count_pre: got %0d want 3", x_count); end
    tensor_ren = 1'b1;
    set        = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (data_out !== e || data_out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_word%0d: got %h/%b want %h/1", i, data_out, data_out_valid, e);
      end
    end
    tensor_ren = 1'b0;
    tick();
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_end: got %b want 0", data_out_valid); end
    checks++; if (x_count !== 7'd0) begin errors++; $display("FAIL drain_count_end: got %0d want 0", x_count); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL drain_err: got %b want 000", err); end
  endtask

  task automatic test_underflow();
    do_reset();
    x_push = 1'b1;
    x_data = 8'h5C;
    tick();
    x_push     = 1'b0;
    tensor_ren = 1'b1;
    set        = 2'd2;
    tick();
    checks++; if (data_out !== 8'h5C || data_out_valid !== 1'b1) begin
      errors++; $display("FAIL under_first: got %h/%b want 5c/1", data_out, data_out_valid);
    end
    tick();
    tensor_ren = 1'b0;
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL under_valid: got %b want 0", data_out_valid); end
    checks++; if (data_out !== 8'h5C) begin errors++; $display("FAIL under_hold: got %h want 5c", data_out); end
    checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL under_err1: got %b want 1", err[1]); end
    tick();
  endtask

  task automatic test_overflow_wrap();
    do_reset();
    for (int i = 0; i <= FD; i++) begin
      x_push = 1'b1;
      x_data = 8'(i);
      tick();
    end
    x_push = 1'b0;
    checks++; if (x_count !== 7'd64) begin errors++; $display("FAIL over_count: got %0d want 64", x_count); end
    checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL over_err1: got %b want 1", err[1]); end
    tensor_ren = 1'b1;
    set        = 2'd2;
    for (int i = 0; i < FD; i++) begin
      tick();
      checks++; if (data_out !== 8'(i) || data_out_valid !== 1'b1) begin
        errors++; $display("FAIL over_pop%0d: got %h/%b want %h/1", i, data_out, data_out_valid, 8'(i));
      end
    end
    tensor_ren = 1'b0;
    tick();
    checks++; if (x_count !== 7'd0) begin errors++; $display("FAIL over_count_end: got %0d want 0", x_count); end
  endtask

  task automatic test_conflict_reset();
    logic [7:0] probe;
    do_reset();
    x_push = 1'b1;
    x_data = 8'h77;
    tick();
    x_push     = 1'b0;
    tensor_wen = 1'b1;
    tensor_ren = 1'b1;
    set        = 2'd0;
    depth_in   = 8'd2;
    width_in   = 8'd2;
    data_in    = 8'h01;
    tick();
    checks++; if (err[2] !== 1'b1) begin errors++; $display("FAIL conflict_err2: got %b want 1", err[2]); end
    checks++; if (data_out_valid !== 1'b0 || x_count !== 7'd1) begin
      errors++; $display("FAIL conflict_nopop: got valid=%b count=%0d want 0/1", data_out_valid, x_count);
    end
    tensor_ren = 1'b0;
    data_in    = 8'h02;
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    tensor_wen = 1'b0;
    checks++; if (loaded !== 4'h0 || err !== 3'b000) begin
      errors++; $display("FAIL midload_rst: got loaded=%h err=%b want 0/000", loaded, err);
    end
    checks++; if (x_count !== 7'd0 || data_out_valid !== 1'b0) begin
      errors++; $display("FAIL midload_rst_fifo: got count=%0d valid=%b want 0/0", x_count, data_out_valid);
    end
    do_load(2'd1, 8'd1, 8'd2, 2, 8'h30, -1, probe);
    checks++; if (loaded !== 4'b0010 || err !== 3'b000) begin
      errors++; $display("FAIL post_rst_load: got loaded=%h err=%b want 2/000", loaded, err);
    end
  endtask

  task automatic test_random_loads();
    logic [7:0] probe;
    logic [3:0] m_loaded;
    logic       m_err0;
    logic [1:0] s;
    logic [7:0] d;
    logic [7:0] w;
    int         n;
    int         exp_len;
    int         a;
    do_reset();
    m_loaded = '0;
    m_err0   = 1'b0;
    do_load(2'd0, 8'd8, 8'd8, 64, -1, -1, probe);
    do_load(2'd1, 8'd8, 8'd8, 64, -1, -1, probe);
    do_load(2'd3, 8'd8, 8'd8, 64, -1, -1, probe);
    m_loaded = 4'b1011;
    checks++; if (loaded !== m_loaded || err !== 3'b000) begin
      errors++; $display("FAIL full_depth_load: got loaded=%h err=%b want b/000", loaded, err);
    end
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(2))
        0:       s = 2'd0;
        1:       s = 2'd1;
        default: s = 2'd3;
      endcase
      d       = 8'($urandom_range(9, 1));
      w       = 8'($urandom_range(9, 1));
      exp_len = (int'(d) * int'(w)) % 128;
      n       = int'(d) * int'(w);
      if ($urandom_range(3) == 0) n = n + 1;
      do_load(s, d, w, n, -1, -1, probe);
      m_loaded[s] = (n == exp_len);
      if (n != exp_len || n > BD) m_err0 = 1'b1;
      checks++; if (loaded !== m_loaded || err[0] !== m_err0) begin
        errors++; $display("FAIL rand_load%0d: got loaded=%h err0=%b want %h/%b", it, loaded, err[0], m_loaded, m_err0);
      end
      for (int r = 0; r < 6; r++) begin
        rd_set  = 2'($urandom_range(3));
        a       = $urandom_range(BD - 1);
        rd_addr = 6'(a);
        tick();
        checks++; if (rd_data !== model_rd(rd_set, a)) begin
          errors++; $display("FAIL rand_rd set=%0d addr=%0d: got %h want %h", rd_set, a, rd_data, model_rd(rd_set, a));
        end
      end
      rd_set = 2'd2;
    end
  endtask

  task automatic test_random_fifo();
    logic [7:0] q[$];
    logic [7:0] last_out;
    logic       m_err1;
    logic       do_push;
    logic       do_pop;
    logic       pop_ok;
    logic       push_ok;
    do_reset();
    last_out = 8'h00;
    m_err1   = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c < 150) begin
        do_push = ($urandom_range(3) != 0);
        do_pop  = ($urandom_range(3) == 0);
      end else begin
        do_push = ($urandom_range(3) == 0);
        do_pop  = ($urandom_range(3) != 0);
      end
      x_push     = do_push;
      x_data     = 8'($urandom);
      tensor_ren = do_pop;
      set        = 2'd2;
      pop_ok  = do_pop && (q.size() > 0);
      push_ok = do_push && (q.size() < FD || pop_ok);
      if (pop_ok) last_out = q.pop_front();
      if (push_ok) q.push_back(x_data);
      if ((do_pop && !pop_ok) || (do_push && !push_ok)) m_err1 = 1'b1;
      tick();
      checks++; if (data_out_valid !== pop_ok || data_out !== last_out) begin
        errors++; $display("FAIL rand_fifo_out c=%0d: got %h/%b want %h/%b", c, data_out, data_out_valid, last_out, pop_ok);
      end
      checks++; if (x_count !== 7'(q.size()) || err[1] !== m_err1) begin
        errors++; $display("FAIL rand_fifo_state c=%0d: got count=%0d err1=%b want %0d/%b", c, x_count, err[1], q.size(), m_err1);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_a();
    test_short_burst();
    test_x_drain();
    test_underflow();
    test_overflow_wrap();
    test_conflict_reset();
    test_random_loads();
    test_random_fifo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
